nt2ascii_stream: RTL
====================

Name: nt2ascii_stream

Overview:
- Streaming decoder from packed 3-bit nucleotide codes back to ASCII characters; inverse of the ASCII-to-nt front end.
- Sits at the alignment output path: takes words of NT_PER_WORD codes (sequence or traceback segments) and serialises them as one ASCII byte per cycle to the host/DMA writer.
- Optional per-word complement and reverse emission order, so reverse-complement strands are written out without a separate pass.

Parameters:
- NT_PER_WORD, 16, number of 3-bit nt codes per input word (>=2)
- LOWERCASE, 0, 1 = emit lowercase a/c/g/t/n, 0 = uppercase; gap is '-' either way

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- in_valid  input  1  input word valid
- in_ready  output  1  block accepts word this cycle
- in_nt  input  3*NT_PER_WORD  packed codes; code i at bits [3i+2:3i]
- in_count  input  $clog2(NT_PER_WORD+1)  number of valid codes, from index 0 upward
- in_last  input  1  word ends the sequence
- in_complement  input  1  complement every code of this word
- in_reverse  input  1  emit highest valid index first
- out_valid  output  1  out_ascii valid
- out_ready  input  1  downstream accepts byte
- out_ascii  output  8  ASCII character
- out_last  output  1  final byte of a word accepted with in_last
- err_count0  output  1  sticky: a word with in_count==0 was accepted

Behaviour:
- Code map (shared with encoder): 0=N, 1=A, 2=C, 3=G, 4=T, 5=gap, 6..7 = N.
- ASCII: A 0x41/0x61, C 0x43/0x63, G 0x47/0x67, T 0x54/0x74, N 0x4E/0x6E, gap 0x2D.
- Complement swaps A<->T and C<->G. N, gap and codes 6..7 are unchanged.
- Accept: in_valid && in_ready. On accept, latch in_nt, in_count, in_last, in_complement and in_reverse into a holding register. Mode inputs matter only at accept.
- States:
  - IDLE: no held word; in_ready=1.
  - EMIT: held word being serialised.
  - IDLE->EMIT on accept with in_count>0.
  - In EMIT, each byte handshake (out_valid && out_ready) advances the index.
  - On the final byte: EMIT->IDLE, or stay in EMIT if a new word is accepted in the same cycle.
- Index order: forward emits idx 0..count-1; reverse emits count-1 down to 0. Index counter width is $clog2(NT_PER_WORD).
- in_ready = (state==IDLE) || (out_valid && out_ready && current byte is final). This gives back-to-back words with no bubble: sustained 1 byte/cycle.
- Latency: word accepted in cycle t -> first byte has out_valid=1 in cycle t+1. out_ascii is registered or decoded combinationally from registered state; no combinational path from in_* to out_*.
- out_valid=1 throughout EMIT. out_ascii, out_last are stable while out_valid && !out_ready (AXI-style hold).
- out_last=1 only on the final emitted byte of a word latched with in_last=1.
- in_count==0: the word is accepted (in_ready as normal) and dropped, producing no bytes. Its in_last is discarded. err_count0 is set and held until rst.
- in_count>NT_PER_WORD: clamp to NT_PER_WORD.
- Reset (including mid-word): state=IDLE, held word discarded, out_valid=0, out_last=0, out_ascii=0x00, err_count0=0, in_ready=0 during rst and 1 in the first cycle after.

Decomposition:
- Shared package (nt_pkg) holds:
  - nt_t (3-bit) and code constants NT_N=0, NT_A=1, NT_C=2, NT_G=3, NT_T=4, NT_GAP=5
  - ASCII constants
  - nt_complement function
  - the encoder also imports this package.
- One combinational sub-module nt2ascii_char: (nt, complement, lowercase) -> 8-bit ASCII. It is instantiated once on the selected code.

Test Plan:
- NT_PER_WORD=4, word codes {1,2,3,4}, count=4, fwd, no comp, out_ready=1 -> bytes 0x41,0x43,0x47,0x54 in cycles t+1..t+4, out_last only if in_last.
- Same word, in_complement=1 and in_reverse=1, in_last=1 -> 0x41,0x43,0x47,0x54 (rev of T,G,C,A), out_last=1 on 4th byte only.
- Two words offered back-to-back, count=4 then count=2 -> 6 consecutive out_valid cycles with no bubble; in_ready=1 exactly in the cycle of byte 4.
- out_ready toggled 1,0,0,1 during a word -> out_ascii held while stalled; no byte lost or duplicated; index advances only on handshake.
- Codes {0,5,6,7} with complement=1, LOWERCASE=1 -> 0x6E,0x2D,0x6E,0x6E. A count=0 word with in_last=1 -> no output, err_count0=1 and it stays set.
- rst asserted after 2 of 4 bytes -> next cycle out_valid=0, out_last=0, err_count0=0. A new word after rst emits from index 0.

Source files
------------

// File: rtl/nt_pkg.sv
// Shared nucleotide definitions: 3-bit code type, code values, ASCII
// characters and the complement helper. Used by both the ASCII-to-nt
// encoder and the nt-to-ASCII stream decoder.
package nt_pkg;

  typedef logic [2:0] nt_t;

  localparam nt_t NT_N   = 3'd0;
  localparam nt_t NT_A   = 3'd1;
  localparam nt_t NT_C   = 3'd2;
  localparam nt_t NT_G   = 3'd3;
  localparam nt_t NT_T   = 3'd4;
  localparam nt_t NT_GAP = 3'd5;

  localparam logic [7:0] ASCII_A_UC = 8'h41;
  localparam logic [7:0] ASCII_C_UC = 8'h43;
  localparam logic [7:0] ASCII_G_UC = 8'h47;
  localparam logic [7:0] ASCII_T_UC = 8'h54;
  localparam logic [7:0] ASCII_N_UC = 8'h4E;
  localparam logic [7:0] ASCII_A_LC = 8'h61;
  localparam logic [7:0] ASCII_C_LC = 8'h63;
  localparam logic [7:0] ASCII_G_LC = 8'h67;
  localparam logic [7:0] ASCII_T_LC = 8'h74;
  localparam logic [7:0] ASCII_N_LC = 8'h6E;
  localparam logic [7:0] ASCII_GAP  = 8'h2D;
  localparam logic [7:0] ASCII_NUL  = 8'h00;

  // Decoder control state: no held word / held word being serialised.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } stream_state_e;

  // Watson-Crick complement; N, gap and the unused codes map to themselves.
  function automatic nt_t nt_complement(input nt_t code);
    nt_t res;
    case (code)
      NT_A:    res = NT_T;
      NT_T:    res = NT_A;
      NT_C:    res = NT_G;
      NT_G:    res = NT_C;
      default: res = code;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/nt2ascii_char.sv
// Combinational translation of one nucleotide code to its ASCII character,
// with optional complement and lowercase selection.
module nt2ascii_char
  import nt_pkg::*;
(
  input  nt_t        nt,
  input  logic       complement,
  input  logic       lowercase,
  output logic [7:0] ascii
);

  nt_t code_s;

  // Apply the optional complement, then map the code to a character.
  always_comb begin
    code_s = nt;
    if (complement) begin
      code_s = nt_complement(nt);
    end else begin
      code_s = nt;
    end
    case (code_s)
      NT_A:    ascii = lowercase ? ASCII_A_LC : ASCII_A_UC;
      NT_C:    ascii = lowercase ? ASCII_C_LC : ASCII_C_UC;
      NT_G:    ascii = lowercase ? ASCII_G_LC : ASCII_G_UC;
      NT_T:    ascii = lowercase ? ASCII_T_LC : ASCII_T_UC;
      NT_GAP:  ascii = ASCII_GAP;
      default: ascii = lowercase ? ASCII_N_LC : ASCII_N_UC;
    endcase
  end

endmodule

// File: rtl/nt2ascii_stream.sv
// Streaming decoder: accepts words of packed 3-bit nucleotide codes and
// serialises them as one ASCII byte per cycle, optionally complemented
// and/or in reverse index order. A new word can be accepted in the same
// cycle as the final byte of the previous one, so throughput is sustained.
module nt2ascii_stream
  import nt_pkg::*;
#(
  parameter int NT_PER_WORD = 16,
  parameter bit LOWERCASE   = 1'b0,
  localparam int CW = $clog2(NT_PER_WORD + 1),
  localparam int IW = $clog2(NT_PER_WORD)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3*NT_PER_WORD-1:0] in_nt,
  input  logic [CW-1:0]            in_count,
  input  logic                     in_last,
  input  logic                     in_complement,
  input  logic                     in_reverse,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_ascii,
  output logic                     out_last,
  output logic                     err_count0
);

  stream_state_e state_r;
  stream_state_e state_next_s;

  nt_t           held_r [NT_PER_WORD];
  logic [CW-1:0] count_r;
  logic          last_r;
  logic          comp_r;
  logic          rev_r;
  logic [IW-1:0] idx_r;
  logic          err_r;

  logic [CW-1:0] count_clamp_s;
  logic [CW-1:0] count_m1_s;
  logic          count_nz_s;
  logic          final_s;
  logic          hs_s;
  logic          in_ready_s;
  logic          accept_s;
  nt_t           code_s;
  logic [7:0]    char_s;

  // Handshake qualifiers, count clamping and final-byte detection.
  always_comb begin
    if (in_count > CW'(NT_PER_WORD)) begin
      count_clamp_s = CW'(NT_PER_WORD);
    end else begin
      count_clamp_s = in_count;
    end
    count_nz_s = (in_count != {CW{1'b0}});
    count_m1_s = count_r - CW'(1);
    if (rev_r) begin
      final_s = (idx_r == {IW{1'b0}});
    end else begin
      final_s = (CW'(idx_r) == count_m1_s);
    end
    hs_s       = (state_r == ST_EMIT) && out_ready;
    in_ready_s = !rst && ((state_r == ST_IDLE) || (hs_s && final_s));
    accept_s   = in_valid && in_ready_s;
    code_s     = held_r[idx_r];
  end

  nt2ascii_char u_char (
    .nt         (code_s),
    .complement (comp_r),
    .lowercase  (LOWERCASE),
    .ascii      (char_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: enter or stay in EMIT whenever a non-empty word is taken.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && count_nz_s) begin
          state_next_s = ST_EMIT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_EMIT: begin
        if (hs_s && final_s) begin
          if (accept_s && count_nz_s) begin
            state_next_s = ST_EMIT;
          end else begin
            state_next_s = ST_IDLE;
          end
        end else begin
          state_next_s = ST_EMIT;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Output decode from registered state; outputs hold while stalled.
  always_comb begin
    in_ready   = in_ready_s;
    err_count0 = err_r;
    if (state_r == ST_EMIT) begin
      out_valid = 1'b1;
      out_ascii = char_s;
      out_last  = last_r && final_s;
    end else begin
      out_valid = 1'b0;
      out_ascii = ASCII_NUL;
      out_last  = 1'b0;
    end
  end

  // Holding register, emission index and sticky empty-word flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NT_PER_WORD; i++) begin
        held_r[i] <= NT_N;
      end
      count_r <= {CW{1'b0}};
      last_r  <= 1'b0;
      comp_r  <= 1'b0;
      rev_r   <= 1'b0;
      idx_r   <= {IW{1'b0}};
      err_r   <= 1'b0;
    end else begin
      if (accept_s && count_nz_s) begin
        for (int i = 0; i < NT_PER_WORD; i++) begin
          held_r[i] <= in_nt[3*i +: 3];
        end
        count_r <= count_clamp_s;
        last_r  <= in_last;
        comp_r  <= in_complement;
        rev_r   <= in_reverse;
        if (in_reverse) begin
          idx_r <= IW'(count_clamp_s - CW'(1));
        end else begin
          idx_r <= {IW{1'b0}};
        end
      end else if (hs_s && !final_s) begin
        if (rev_r) begin
          idx_r <= idx_r - IW'(1);
        end else begin
          idx_r <= idx_r + IW'(1);
        end
      end else begin
        idx_r <= idx_r;
      end
      if (accept_s && !count_nz_s) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end
    end
  end

endmodule
